// File: rtl/motor_pkg.sv
// Shared motor-drive types and helpers.
// Used by the PWM driver and the PWM demodulator.
package motor_pkg;

    localparam int BITS_DEF = 12;

    typedef enum logic [1:0] {
        UNK,
        POS,
        NEG
    } sign_t;

    function automatic int sat_s(input int v, input int bits);
        int hi;
        int lo;
        hi = (1 << (bits - 1)) - 1;
        lo = -(1 << (bits - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/pwm_demod_if.sv
// Pin-side and result bundle of the PWM demodulator.
// master drives the bridge lines, slave is the demodulator.
interface pwm_demod_if
    import motor_pkg::*;
#(
    parameter int BITS = BITS_DEF
);

    logic                   EN;
    logic                   OUT1;
    logic                   OUT2;
    logic                   CLR_FAULT;
    logic signed [BITS-1:0] DUTY;
    logic                   DUTY_VALID;
    logic [15:0]            PERIOD;
    logic                   PERIOD_VALID;
    logic                   SHOOT_THROUGH;

    modport master (
        output EN,
        output OUT1,
        output OUT2,
        output CLR_FAULT,
        input  DUTY,
        input  DUTY_VALID,
        input  PERIOD,
        input  PERIOD_VALID,
        input  SHOOT_THROUGH
    );

    modport slave (
        input  EN,
        input  OUT1,
        input  OUT2,
        input  CLR_FAULT,
        output DUTY,
        output DUTY_VALID,
        output PERIOD,
        output PERIOD_VALID,
        output SHOOT_THROUGH
    );

endinterface

// File: rtl/pwm_duty_window.sv
// Registers the bridge lines and integrates a signed duty per window.
// The close value is shifted/saturated one cycle after the window ends.
module pwm_duty_window
    import motor_pkg::*;
#(
    parameter int BITS   = BITS_DEF,
    parameter int WINDOW = 8192
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   en,
    input  logic                   out1,
    input  logic                   out2,
    output logic                   en_r,
    output logic                   a_r,
    output logic                   b_r,
    output logic                   close_v,
    output logic signed [BITS-1:0] duty_nxt,
    output logic signed [BITS-1:0] duty,
    output logic                   duty_valid
);

    localparam int LW = $clog2(WINDOW);
    localparam int AW = LW + 2;
    localparam int SH = LW - BITS + 1;
    localparam logic signed [AW-1:0] ONE = 1;

    logic [LW-1:0]          wcnt;
    logic signed [AW-1:0]   acc;
    logic signed [AW-1:0]   acc_n;
    logic signed [AW-1:0]   acc_f;
    logic signed [AW-1:0]   acc_s;
    logic                   close_r;

    // fault cycles (both lines high) fall through and add nothing
    always_comb begin
        acc_n = acc;
        if (a_r & ~b_r)
            acc_n = acc + ONE;
        else if (b_r & ~a_r)
            acc_n = acc - ONE;
    end

    always_comb begin
        acc_s    = acc_f >>> SH;
        duty_nxt = BITS'(sat_s(int'(acc_s), BITS));
        close_v  = close_r & en_r;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            en_r       <= 1'b0;
            a_r        <= 1'b0;
            b_r        <= 1'b0;
            wcnt       <= '0;
            acc        <= '0;
            acc_f      <= '0;
            close_r    <= 1'b0;
            duty       <= '0;
            duty_valid <= 1'b0;
        end else begin
            en_r       <= en;
            a_r        <= out1;
            b_r        <= out2;
            close_r    <= 1'b0;
            duty_valid <= close_v;
            if (close_v)
                duty <= duty_nxt;
            if (!en_r) begin
                wcnt <= '0;
                acc  <= '0;
            end else if (&wcnt) begin
                wcnt    <= '0;
                acc     <= '0;
                acc_f   <= acc_n;
                close_r <= 1'b1;
            end else begin
                wcnt <= wcnt + LW'(1);
                acc  <= acc_n;
            end
        end
    end

endmodule

// File: rtl/pwm_demod.sv
// PWM demodulator: windowed duty, sign tracking, period and fault.
// Decisions use the duty being registered so strobes coincide.
module pwm_demod
    import motor_pkg::*;
#(
    parameter int BITS   = BITS_DEF,
    parameter int WINDOW = 8192,
    parameter int HYST   = 64
) (
    input  logic      CLK,
    input  logic      RESET_N,
    pwm_demod_if.slave bus
);

    localparam logic signed [BITS-1:0] HP = BITS'(HYST);
    localparam logic signed [BITS-1:0] HN = -HP;

    logic                   en_r;
    logic                   a_r;
    logic                   b_r;
    logic                   close_v;
    logic signed [BITS-1:0] duty_nxt;
    logic signed [BITS-1:0] duty;
    logic                   duty_valid;

    sign_t                  state;
    logic [15:0]            win_ctr;
    logic                   armed;
    logic [15:0]            period;
    logic                   period_valid;
    logic                   shoot;

    logic                   pos_in;
    logic                   neg_in;
    logic                   rise;
    logic                   ctr_sat;

    pwm_duty_window #(
        .BITS   (BITS),
        .WINDOW (WINDOW)
    ) u_win (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .en         (bus.EN),
        .out1       (bus.OUT1),
        .out2       (bus.OUT2),
        .en_r       (en_r),
        .a_r        (a_r),
        .b_r        (b_r),
        .close_v    (close_v),
        .duty_nxt   (duty_nxt),
        .duty       (duty),
        .duty_valid (duty_valid)
    );

    always_comb begin
        pos_in  = duty_nxt >= HP;
        neg_in  = duty_nxt <= HN;
        rise    = (state == NEG) && pos_in;
        ctr_sat = &win_ctr;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= UNK;
            win_ctr      <= '0;
            armed        <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            shoot        <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (en_r & a_r & b_r)
                shoot <= 1'b1;
            else if (bus.CLR_FAULT)
                shoot <= 1'b0;
            if (!en_r) begin
                state   <= UNK;
                armed   <= 1'b0;
                win_ctr <= '0;
            end else if (close_v) begin
                // above +HYST always lands in POS, below -HYST in NEG
                if (pos_in)
                    state <= POS;
                else if (neg_in)
                    state <= NEG;
                unique case (1'b1)
                    rise: begin
                        if (armed && !ctr_sat) begin
                            period       <= win_ctr + 16'd1;
                            period_valid <= 1'b1;
                        end
                        win_ctr <= '0;
                        armed   <= 1'b1;
                    end
                    (!rise && !ctr_sat): win_ctr <= win_ctr + 16'd1;
                    default: ;
                endcase
            end
        end
    end

    assign bus.DUTY          = duty;
    assign bus.DUTY_VALID    = duty_valid;
    assign bus.PERIOD        = period;
    assign bus.PERIOD_VALID  = period_valid;
    assign bus.SHOOT_THROUGH = shoot;

endmodule

// File: tb/tb_pwm_demod.sv
// Directed bench for pwm_demod at a reduced window size.
// Strobes are logged on the falling edge with their edge count.
module tb_pwm_demod;
    import motor_pkg::*;

    localparam int BITS = 8;
    localparam int W    = 256;
    localparam int HYST = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int c0;
    int dq[$];
    int dt[$];
    int pq[$];
    int pt[$];

    pwm_demod_if #(.BITS(BITS)) bus();

    pwm_demod #(
        .BITS   (BITS),
        .WINDOW (W),
        .HYST   (HYST)
    ) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.DUTY_VALID) begin
            dq.push_back(int'(bus.DUTY));
            dt.push_back(cyc);
        end
        if (bus.PERIOD_VALID) begin
            pq.push_back(int'(bus.PERIOD));
            pt.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        if (i < 0 || i >= q.size()) return -99999;
        return q[i];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        dq.delete();
        dt.delete();
        pq.delete();
        pt.delete();
    endtask

    // 0: n x OUT1 then idle, 1: antiphase, 2: n x OUT2 then idle,
    // 3: n x OUT1 then OUT2 for the rest
    task automatic drive_win(input int kind, input int n);
        for (int i = 0; i < W; i++) begin
            case (kind)
                0: begin bus.OUT1 = (i < n); bus.OUT2 = 1'b0; end
                1: begin bus.OUT1 = i[0]; bus.OUT2 = ~i[0]; end
                2: begin bus.OUT1 = 1'b0; bus.OUT2 = (i < n); end
                default: begin bus.OUT1 = (i < n); bus.OUT2 = (i >= n); end
            endcase
            step();
        end
    endtask

    task automatic en_off();
        bus.EN   = 1'b0;
        bus.OUT1 = 1'b0;
        bus.OUT2 = 1'b0;
        repeat (4) step();
        clear_q();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bus.EN        = 1'b0;
        bus.OUT1      = 1'b0;
        bus.OUT2      = 1'b0;
        bus.CLR_FAULT = 1'b0;
        repeat (3) step();
        chk("rst_duty", int'(bus.DUTY), 0);
        chk("rst_dv", int'(bus.DUTY_VALID), 0);
        chk("rst_period", int'(bus.PERIOD), 0);
        chk("rst_pv", int'(bus.PERIOD_VALID), 0);
        chk("rst_st", int'(bus.SHOOT_THROUGH), 0);
        rst_n = 1'b1;
        repeat (2) step();

        // full positive
        clear_q();
        bus.EN = 1'b1;
        c0 = cyc;
        repeat (3) drive_win(0, W);
        chk("pos_ndv", dq.size(), 2);
        chk("pos_duty0", qat(dq, 0), 127);
        chk("pos_lat", qat(dt, 0) - c0, W + 2);
        chk("pos_duty1", qat(dq, 1), 127);
        chk("pos_gap", qat(dt, 1) - qat(dt, 0), W);
        chk("pos_npv", pq.size(), 0);
        en_off();

        // balanced, full negative, quarter positive
        bus.EN = 1'b1;
        drive_win(1, 0);
        drive_win(2, W);
        drive_win(0, W / 4);
        repeat (3) step();
        chk("mix_ndv", dq.size(), 3);
        chk("bal_duty", qat(dq, 0), 0);
        chk("neg_duty", qat(dq, 1), -128);
        chk("qtr_duty", qat(dq, 2), 32);
        chk("mix_npv", pq.size(), 0);
        en_off();

        // square wave, 4 up / 4 down, with sub-hysteresis excursions
        bus.EN = 1'b1;
        repeat (4) drive_win(3, 192);
        repeat (4) drive_win(3, 64);
        drive_win(3, 192);
        drive_win(2, 16);
        repeat (2) drive_win(3, 192);
        drive_win(3, 64);
        drive_win(0, 16);
        repeat (2) drive_win(3, 64);
        repeat (4) drive_win(3, 192);
        repeat (4) drive_win(3, 64);
        drive_win(3, 192);
        repeat (3) step();
        chk("sq_ndv", dq.size(), 25);
        chk("sq_hi", qat(dq, 0), 64);
        chk("sq_lo", qat(dq, 4), -64);
        chk("sq_exc_n", qat(dq, 9), -8);
        chk("sq_exc_p", qat(dq, 13), 8);
        chk("sq_npv", pq.size(), 2);
        chk("sq_per0", qat(pq, 0), 8);
        chk("sq_per1", qat(pq, 1), 8);
        chk("sq_pv_at", qat(pt, 0), qat(dt, 16));
        chk("sq_pv_gap", qat(pt, 1) - qat(pt, 0), 8 * W);
        en_off();

        // EN drop mid-window, then restart without arming
        bus.EN   = 1'b1;
        bus.OUT1 = 1'b1;
        repeat (157) step();
        bus.EN   = 1'b0;
        bus.OUT1 = 1'b0;
        repeat (2 * W) step();
        chk("drop_ndv", dq.size(), 0);
        bus.EN = 1'b1;
        c0 = cyc;
        drive_win(3, 64);
        drive_win(3, 192);
        drive_win(3, 64);
        drive_win(3, 192);
        repeat (3) step();
        chk("re_ndv", dq.size(), 4);
        chk("re_lat", qat(dt, 0) - c0, W + 2);
        chk("re_npv", pq.size(), 1);
        chk("re_per", qat(pq, 0), 2);
        chk("re_pv_at", qat(pt, 0), qat(dt, 3));

        // shoot-through
        bus.OUT1 = 1'b1;
        bus.OUT2 = 1'b1;
        step();
        chk("st_lat", int'(bus.SHOOT_THROUGH), 0);
        bus.OUT1 = 1'b0;
        bus.OUT2 = 1'b0;
        step();
        chk("st_set", int'(bus.SHOOT_THROUGH), 1);
        repeat (5) step();
        chk("st_sticky", int'(bus.SHOOT_THROUGH), 1);
        bus.CLR_FAULT = 1'b1;
        step();
        bus.CLR_FAULT = 1'b0;
        chk("st_clr", int'(bus.SHOOT_THROUGH), 0);
        bus.OUT1 = 1'b1;
        bus.OUT2 = 1'b1;
        step();
        bus.OUT1      = 1'b0;
        bus.OUT2      = 1'b0;
        bus.CLR_FAULT = 1'b1;
        step();
        bus.CLR_FAULT = 1'b0;
        chk("st_setwins", int'(bus.SHOOT_THROUGH), 1);
        step();
        chk("st_hold", int'(bus.SHOOT_THROUGH), 1);
        bus.CLR_FAULT = 1'b1;
        step();
        bus.CLR_FAULT = 1'b0;
        chk("st_clr2", int'(bus.SHOOT_THROUGH), 0);
        en_off();

        // asynchronous reset mid-window
        bus.EN   = 1'b1;
        bus.OUT1 = 1'b1;
        repeat (W + 100) step();
        bus.OUT2 = 1'b1;
        step();
        bus.OUT2 = 1'b0;
        repeat (2) step();
        chk("pre_duty", qat(dq, 0), 127);
        chk("pre_period", int'(bus.PERIOD), 2);
        chk("pre_st", int'(bus.SHOOT_THROUGH), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_duty", int'(bus.DUTY), 0);
        chk("ar_dv", int'(bus.DUTY_VALID), 0);
        chk("ar_period", int'(bus.PERIOD), 0);
        chk("ar_pv", int'(bus.PERIOD_VALID), 0);
        chk("ar_st", int'(bus.SHOOT_THROUGH), 0);
        repeat (3) step();
        clear_q();
        rst_n = 1'b1;
        c0 = cyc;
        repeat (2 * W + 3) step();
        chk("rr_ndv", dq.size(), 2);
        chk("rr_duty0", qat(dq, 0), 127);
        chk("rr_lat", qat(dt, 0) - c0, W + 2);
        chk("rr_gap", qat(dt, 1) - qat(dt, 0), W);
        chk("rr_npv", pq.size(), 0);
        chk("rr_period", int'(bus.PERIOD), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
